// File: rtl/arm7_mem_bus_if.sv
// -----------------------------------------------------------------------------
// arm7_mem_bus_if
//
// Bus-side stage that sits after the memory unit's alignment/byte-enable logic.
// It takes one load/store request at a time and runs it on a simple req/ack
// external bus. It generates byte lanes and replicated write data, waits out
// bus wait states, and aligns and extends load data the way ARM7TDMI does,
// including the rotated result of a misaligned LDR.
//
// Optional feature (macro MEM_BUS_TIMEOUT_EN):
//   When the macro is defined, a bus cycle that gets no ack within
//   TIMEOUT_CYCLES cycles is aborted. When it is not defined, the block waits
//   for an ack with no limit and TIMEOUT_CYCLES is unused.
//
// Ports:
//   clk, rst_n          core clock; asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_addr/size/write/signed/wdata   request fields, registered on accept
//   rsp_valid           one-cycle response pulse, no backpressure
//   rsp_rdata           aligned/extended load data (0 for stores and aborts)
//   rsp_abort           bus error, timeout or illegal size (only with rsp_valid)
//   bus_req/addr/we/be/wdata  external bus outputs, all 0 outside a bus cycle
//   bus_ack/err/rdata   external bus inputs
// -----------------------------------------------------------------------------
module arm7_mem_bus_if #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_write,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_abort,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        signed_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        abort_q;

    logic        accept;
    logic        illegal;
    logic        tmo_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_data;

    assign accept  = req_valid && req_ready;
    assign illegal = (req_size == 2'b11);

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;

    // The last allowed cycle is the one where the counter reads TIMEOUT_CYCLES-1;
    // an ack in that same cycle still completes the transfer normally.
    assign tmo_hit = (state == BUS) && !bus_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == BUS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output is given a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = illegal ? RESP : BUS;
            BUS:  if (bus_ack || tmo_hit) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Request-side lane generation ----------------
    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = req_wdata;
        case (req_size)
            2'b00: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be_calc    = 4'b1111;
                wdata_calc = req_wdata;
            end
            default: begin
                be_calc    = 4'b0000;
                wdata_calc = '0;
            end
        endcase
    end

    // ---------------- Load alignment / extension ----------------
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v    = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v    = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_data = bus_rdata;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_v[7]}}, byte_v};
            2'b01:   load_data = {{16{signed_q & half_v[15]}}, half_v};
            default: begin
                // Misaligned LDR returns the addressed word rotated right by 8*addr[1:0].
                case (addr_q[1:0])
                    2'd0:    load_data = bus_rdata;
                    2'd1:    load_data = {bus_rdata[7:0],  bus_rdata[31:8]};
                    2'd2:    load_data = {bus_rdata[15:0], bus_rdata[31:16]};
                    default: load_data = {bus_rdata[23:0], bus_rdata[31:24]};
                endcase
            end
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            abort_q  <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            write_q  <= req_write;
            signed_q <= req_signed;
            be_q     <= be_calc;
            wdata_q  <= wdata_calc;
            rdata_q  <= '0;
            abort_q  <= illegal;
        end else if (state == BUS) begin
            if (bus_ack) begin
                rdata_q <= (write_q || bus_err) ? 32'd0 : load_data;
                abort_q <= bus_err;
            end else if (tmo_hit) begin
                rdata_q <= '0;
                abort_q <= 1'b1;
            end
        end
    end

    // ---------------- Outputs ----------------
    // Bus and response outputs are gated by state so they read 0 outside
    // their active cycles, including immediately on reset.
    assign req_ready = (state == IDLE);
    assign bus_req   = (state == BUS);
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_we    = bus_req & write_q;
    assign bus_be    = bus_req ? be_q : 4'b0000;
    assign bus_wdata = bus_req ? wdata_q : 32'd0;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_abort = rsp_valid & abort_q;

endmodule
